call_dispatcher: RTL

Central call-stack controller that drives the compiled function modules. It launches `MAIN_FUNC` on a host request and services every `nontailCall` by pushing the caller's frame and starting the callee. It services every `endOfFunc` by popping a frame and resuming the caller with the return value on `get`. It is the caller side of the function start/return protocol; function modules connect to it in parallel, indexed by function id.

---
 rtl/call_dispatcher.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/call_dispatcher.sv
// ---------------------------------------------------------------------------
// call_dispatcher
//
// Central call-stack controller for the compiled function modules. A host
// `run` launches MAIN_FUNC. While a function runs, its `nontailCall` pushes
// the caller's frame and starts the callee. Its `endOfFunc` either finishes
// the whole computation or pops a frame and resumes the caller, with the
// callee's return value on `get`.
//
// Ports
//   clk, rstn            : clock, asynchronous active-low reset
//   run, run_args        : host start request and MAIN_FUNC arguments
//   busy, done, result   : activity flag, completion pulse, MAIN_FUNC result
//   error                : sticky protocol/overflow error, cleared by run
//   sp                   : current frame stack depth
//   start                : one-hot start strobe, bit = function id
//   args, get, restore   : broadcast call args, return value, frame
//   endOfFunc/nontailCall: per-function completion/call flags
//   call_args/ret/func/save : per-function call args, return value,
//                          callee id and frame to save
// ---------------------------------------------------------------------------
module call_dispatcher #(
    parameter int NUM_FUNC  = 10,
    parameter int ARITY     = 2,
    parameter int DATA_W    = 32,
    parameter int FRAME_W   = 7,
    parameter int DEPTH     = 64,
    parameter int MAIN_FUNC = 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                run,
    input  logic [ARITY*DATA_W-1:0]             run_args,
    output logic                                busy,
    output logic                                done,
    output logic [DATA_W-1:0]                   result,
    output logic                                error,
    output logic [$clog2(DEPTH+1)-1:0]          sp,
    output logic [NUM_FUNC-1:0]                 start,
    output logic [ARITY*DATA_W-1:0]             args,
    output logic [DATA_W-1:0]                   get,
    output logic [FRAME_W*DATA_W-1:0]           restore,
    input  logic [NUM_FUNC-1:0]                 endOfFunc,
    input  logic [NUM_FUNC-1:0]                 nontailCall,
    input  logic [NUM_FUNC*ARITY*DATA_W-1:0]    call_args,
    input  logic [NUM_FUNC*DATA_W-1:0]          ret,
    input  logic [NUM_FUNC*DATA_W-1:0]          func,
    input  logic [NUM_FUNC*FRAME_W*DATA_W-1:0]  save
);

    localparam int SP_W     = $clog2(DEPTH + 1);
    localparam int FID_W    = $clog2(NUM_FUNC);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ARG_BITS = ARITY * DATA_W;
    localparam int FRM_BITS = FRAME_W * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_ERROR} state_t;

    // What the active function asked for this cycle.
    typedef enum logic [2:0] {EV_NONE, EV_PUSH, EV_RET, EV_POP, EV_ERR} event_t;

    typedef struct packed {
        logic [FID_W-1:0]    fid;
        logic [FRM_BITS-1:0] frame;
    } frame_t;

    function automatic logic [NUM_FUNC-1:0] onehot(input logic [FID_W-1:0] id);
        return NUM_FUNC'(1) << id;
    endfunction

    state_t                state_q;
    logic [FID_W-1:0]      cur_func_q;
    logic [SP_W-1:0]       sp_q;
    logic [ARG_BITS-1:0]   args_q;
    logic [FRM_BITS-1:0]   restore_q;
    logic [DATA_W-1:0]     get_q;
    logic [DATA_W-1:0]     result_q;
    logic                  done_q;
    logic                  error_q;
    logic [NUM_FUNC-1:0]   start_q;

    frame_t                stack_mem [DEPTH];

    // Only the active slot's outputs are ever looked at.
    logic                  cur_eof;
    logic                  cur_call;
    logic [DATA_W-1:0]     cur_ret;
    logic [DATA_W-1:0]     cur_target;
    logic [ARG_BITS-1:0]   cur_call_args;
    logic [FRM_BITS-1:0]   cur_save;
    logic                  target_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    frame_t                top;
    event_t                ev;

    assign cur_eof       = endOfFunc[cur_func_q];
    assign cur_call      = nontailCall[cur_func_q];
    assign cur_ret       = ret[int'(cur_func_q)*DATA_W +: DATA_W];
    assign cur_target    = func[int'(cur_func_q)*DATA_W +: DATA_W];
    assign cur_call_args = call_args[int'(cur_func_q)*ARG_BITS +: ARG_BITS];
    assign cur_save      = save[int'(cur_func_q)*FRM_BITS +: FRM_BITS];
    assign target_ok     = (cur_target != '0) && (cur_target < DATA_W'(NUM_FUNC));

    // Top-of-stack is read combinationally so the popped frame is already
    // on `restore` during the LAUNCH cycle that follows.
    assign wr_idx = IDX_W'(sp_q);
    assign rd_idx = IDX_W'(sp_q - SP_W'(1));
    assign top    = stack_mem[rd_idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a
        // path that leaves it unassigned infers a latch.
        ev = EV_NONE;
        if (state_q == S_RUN) begin
            if (cur_call && cur_eof) begin
                ev = EV_ERR;
            end else if (cur_call) begin
                ev = ((sp_q == SP_W'(DEPTH)) || !target_ok) ? EV_ERR : EV_PUSH;
            end else if (cur_eof) begin
                ev = (sp_q == '0) ? EV_RET : EV_POP;
            end
        end
    end

    // NOTE: frame storage has no reset; sp alone says which entries are live,
    // so leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ev == EV_PUSH) begin
            stack_mem[wr_idx] <= '{fid: cur_func_q, frame: cur_save};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cur_func_q <= '0;
            sp_q       <= '0;
            args_q     <= '0;
            restore_q  <= '0;
            get_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            start_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            start_q <= '0;
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (run) begin
                        cur_func_q <= FID_W'(MAIN_FUNC);
                        args_q     <= run_args;
                        restore_q  <= '0;
                        get_q      <= '0;
                        sp_q       <= '0;
                        error_q    <= 1'b0;
                        start_q    <= onehot(FID_W'(MAIN_FUNC));
                        state_q    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    case (ev)
                        EV_PUSH: begin
                            sp_q       <= sp_q + SP_W'(1);
                            cur_func_q <= FID_W'(cur_target);
                            args_q     <= cur_call_args;
                            restore_q  <= '0;
                            start_q    <= onehot(FID_W'(cur_target));
                            state_q    <= S_LAUNCH;
                        end
                        EV_RET: begin
                            result_q <= cur_ret;
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                        EV_POP: begin
                            sp_q       <= sp_q - SP_W'(1);
                            cur_func_q <= top.fid;
                            restore_q  <= top.frame;
                            get_q      <= cur_ret;
                            args_q     <= '0;
                            start_q    <= onehot(top.fid);
                            state_q    <= S_LAUNCH;
                        end
                        EV_ERR: begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign done    = done_q;
    assign result  = result_q;
    assign error   = error_q;
    assign sp      = sp_q;
    assign start   = start_q;
    assign args    = args_q;
    assign get     = get_q;
    assign restore = restore_q;

endmodule
